uart_rx_core: RTL and testbench

- Oversampling UART receiver; the downstream consumer of the UART transmitter's serial line (tx_out → rx_in).
- Frame format matches the transmitter: start bit (0), dataWidth data bits LSB first, optional parity bit, one stop bit (1).
- Delivers the recovered byte on p_data with a one-cycle data_valid strobe.
- Flags parity and stop-bit errors to the UART control logic.

---
 rtl/uart_rx_core.sv | 95 +++++++++
 tb/tb_uart_rx_core.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with 3-sample majority vote,
// start-glitch rejection, parity and stop-bit checking.
module uart_rx_core #(
  parameter int dataWidth = 8,
  parameter int prescaleWidth = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_in,
  input  logic [prescaleWidth-1:0] prescale,
  input  logic                     par_en,
  input  logic                     par_type,
  output logic [dataWidth-1:0]     p_data,
  output logic                     data_valid,
  output logic                     par_err,
  output logic                     stp_err,
  output logic                     busy
);
  localparam int BW = $clog2(dataWidth) + 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0] state;
  logic [1:0] sync;
  logic rx_s;
  logic [prescaleWidth-1:0] edge_cnt, p, half;
  logic [BW-1:0] bit_cnt;
  logic [2:0] smp;
  logic [dataWidth-1:0] data;
  logic pe, pt, par_flag, maj, decide, bit_end;
  assign rx_s = sync[1];
  assign half = p >> 1;
  assign maj = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign decide = edge_cnt == half + prescaleWidth'(2);
  assign bit_end = edge_cnt == p - prescaleWidth'(1);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync       <= 2'b11;
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p          <= '0;
      pe         <= 1'b0;
      pt         <= 1'b0;
      smp        <= '0;
      data       <= '0;
      par_flag   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      sync       <= {sync[0], rx_in};
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state == IDLE) begin
        // the detection cycle itself is edge 0 of the start bit
        edge_cnt <= rx_s ? '0 : prescaleWidth'(1);
        bit_cnt  <= '0;
        par_flag <= 1'b0;
        if (!rx_s) begin
          state <= START;
          p     <= prescale;
          pe    <= par_en;
          pt    <= par_type;
        end
      end else begin
        edge_cnt <= bit_end ? '0 : edge_cnt + prescaleWidth'(1);
        if (edge_cnt == half - prescaleWidth'(1)) smp[0] <= rx_s;
        if (edge_cnt == half) smp[1] <= rx_s;
        if (edge_cnt == half + prescaleWidth'(1)) smp[2] <= rx_s;
        if (state == START && decide && maj) begin
          state    <= IDLE;
          edge_cnt <= '0;
        end else if (state == START && bit_end) state <= DATA;
        if (state == DATA && decide) begin
          data    <= {maj, data[dataWidth-1:1]};
          bit_cnt <= bit_cnt + BW'(1);
        end
        if (state == DATA && bit_end && bit_cnt == BW'(dataWidth)) state <= pe ? PARITY : STOP;
        if (state == PARITY && decide) par_flag <= maj ^ (^data) ^ pt;
        if (state == PARITY && bit_end) state <= STOP;
        // stop decision ends the frame early so back-to-back starts are caught
        if (state == STOP && decide) begin
          state      <= IDLE;
          edge_cnt   <= '0;
          stp_err    <= !maj;
          par_err    <= par_flag;
          data_valid <= maj & !par_flag;
          if (maj & !par_flag) p_data <= data;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized and directed frames checked against a frame-level model.
module tb_uart_rx_core;
  logic clk = 0, rst = 0, rx_in = 1, par_en = 0, par_type = 0;
  logic [5:0] prescale = 6'd8;
  logic [7:0] p_data;
  logic data_valid, par_err, stp_err, busy;
  int asserts = 0, failures = 0;
  int n_valid = 0, n_par = 0, n_stp = 0, bad_busy = 0;
  bit busy_seen = 0;
  logic [7:0] pd_q[$];
  int exp_nv = 0, exp_np = 0, exp_ns = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_pd = 0;

  uart_rx_core #(.dataWidth(8), .prescaleWidth(6)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
    .par_type(par_type), .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin n_valid++; pd_q.push_back(p_data); end
    if (par_err) n_par++;
    if (stp_err) n_stp++;
    if ((data_valid || par_err || stp_err) && busy) bad_busy++;
    if (busy) busy_seen = 1;
  end

  task automatic clr();
    n_valid = 0; n_par = 0; n_stp = 0; bad_busy = 0; busy_seen = 0;
    pd_q.delete(); exp_q.delete(); exp_nv = 0; exp_np = 0; exp_ns = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int p);
    rx_in = b;
    cycles(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip, input bit sb, input bit scramble);
    int p;
    logic e, t, pb;
    p = prescale; e = par_en; t = par_type;
    pb = (^d) ^ t ^ flip;
    drive_bit(1'b0, p);
    if (scramble) begin
      prescale = 6'($urandom_range(8, 40)); par_en = ~e; par_type = ~t;
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (e) drive_bit(pb, p);
    drive_bit(sb, p);
    rx_in = 1'b1;
    if (scramble) begin prescale = 6'(p); par_en = e; par_type = t; end
    if (e && pb != ((^d) ^ t)) exp_np++;
    if (!sb) exp_ns++;
    if (!(e && pb != ((^d) ^ t)) && sb) begin exp_nv++; exp_pd = d; exp_q.push_back(d); end
  endtask

  task automatic test_reset();
    rst = 0; cycles(3);
    asserts++; if (p_data !== 8'h00) begin failures++; $display("FAIL reset_p_data got %h want 00", p_data); end
    asserts++; if ({data_valid, par_err, stp_err, busy} !== 4'b0) begin failures++; $display("FAIL reset_flags got %b want 0000", {data_valid, par_err, stp_err, busy}); end
    rst = 1; cycles(4);
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    clr(); prescale = 8; par_en = 1; par_type = 0;
    send_frame(8'hA5, 0, 1, 0); cycles(16);
    asserts++; if (n_valid !== 1) begin failures++; $display("FAIL basic_valid_count got %0d want 1", n_valid); end
    asserts++; if (p_data !== 8'hA5) begin failures++; $display("FAIL basic_p_data got %h want a5", p_data); end
    asserts++; if (n_par + n_stp !== 0) begin failures++; $display("FAIL basic_errors got %0d want 0", n_par + n_stp); end
    asserts++; if (bad_busy !== 0) begin failures++; $display("FAIL basic_busy_at_strobe got %0d want 0", bad_busy); end
  endtask

  task automatic test_parity_err();
    clr(); prescale = 8; par_en = 1; par_type = 0;
    send_frame(8'h3C, 1, 1, 0); cycles(16);
    asserts++; if (n_par !== 1) begin failures++; $display("FAIL parerr_count got %0d want 1", n_par); end
    asserts++; if (n_valid !== 0) begin failures++; $display("FAIL parerr_valid got %0d want 0", n_valid); end
    asserts++; if (p_data !== 8'hA5) begin failures++; $display("FAIL parerr_p_data got %h want a5", p_data); end
  endtask

  task automatic test_stop_err();
    clr(); prescale = 16; par_en = 0;
    send_frame(8'h81, 0, 0, 0); cycles(48);
    asserts++; if (n_stp !== 1) begin failures++; $display("FAIL stperr_count got %0d want 1", n_stp); end
    asserts++; if (n_valid + n_par !== 0) begin failures++; $display("FAIL stperr_other got %0d want 0", n_valid + n_par); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL stperr_busy got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    clr(); prescale = 8; par_en = 0;
    rx_in = 0; cycles(2); rx_in = 1; cycles(20);
    asserts++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen got %b want 1", busy_seen); end
    asserts++; if (busy !== 1'b0 || n_valid + n_par + n_stp !== 0) begin failures++; $display("FAIL glitch_idle busy %b strobes %0d want 0/0", busy, n_valid + n_par + n_stp); end
    send_frame(8'h55, 0, 1, 0); cycles(16);
    asserts++; if (n_valid !== 1 || p_data !== 8'h55) begin failures++; $display("FAIL glitch_next got %0d/%h want 1/55", n_valid, p_data); end
  endtask

  task automatic test_back_to_back();
    clr(); prescale = 16; par_en = 1; par_type = 1;
    send_frame(8'h00, 0, 1, 0);
    send_frame(8'hFF, 0, 1, 0); cycles(32);
    asserts++; if (pd_q.size() !== 2) begin failures++; $display("FAIL b2b_count got %0d want 2", pd_q.size()); end
    else begin
      asserts++; if (pd_q[0] !== 8'h00 || pd_q[1] !== 8'hFF) begin failures++; $display("FAIL b2b_data got %h %h want 00 ff", pd_q[0], pd_q[1]); end
    end
    asserts++; if (n_par + n_stp !== 0) begin failures++; $display("FAIL b2b_errors got %0d want 0", n_par + n_stp); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    clr(); prescale = 8; par_en = 0; d = 8'hC3;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    rx_in = d[4]; cycles(4);
    rst = 0; rx_in = 1; cycles(1); rst = 1;
    exp_pd = 0; cycles(40);
    asserts++; if ({p_data, data_valid, par_err, stp_err, busy} !== 12'b0) begin failures++; $display("FAIL midrst_outputs got %h want 000", {p_data, data_valid, par_err, stp_err, busy}); end
    asserts++; if (n_valid + n_par + n_stp !== 0) begin failures++; $display("FAIL midrst_strobes got %0d want 0", n_valid + n_par + n_stp); end
    send_frame(8'h5A, 0, 1, 0); cycles(16);
    asserts++; if (n_valid !== 1 || p_data !== 8'h5A) begin failures++; $display("FAIL midrst_next got %0d/%h want 1/5a", n_valid, p_data); end
  endtask

  task automatic test_random();
    int ps[3] = '{8, 16, 32};
    for (int k = 0; k < 12; k++) begin
      clr();
      prescale = 6'(ps[$urandom_range(0, 2)]);
      par_en = 1'($urandom); par_type = 1'($urandom);
      send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0, 1'($urandom));
      cycles(3 * 32);
      asserts++; if (n_valid !== exp_nv || n_par !== exp_np || n_stp !== exp_ns) begin failures++; $display("FAIL rand%0d_strobes got v%0d p%0d s%0d want v%0d p%0d s%0d", k, n_valid, n_par, n_stp, exp_nv, exp_np, exp_ns); end
      asserts++; if (p_data !== exp_pd) begin failures++; $display("FAIL rand%0d_p_data got %h want %h", k, p_data, exp_pd); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
